// File: rtl/queue_dispatch_ctrl_if.sv
// Ticket/call bus between the customer/counter side and the dispatch controller.
interface queue_dispatch_ctrl_if #(
  parameter int NUM_COUNTERS = 5,
  parameter int NUM_W        = 6
);
  logic                          button;
  logic [NUM_COUNTERS-1:0]       done;
  logic [NUM_W-1:0]              ticket_number;
  logic [NUM_W-1:0]              max_call_number;
  logic [NUM_W-1:0]              waiting_count;
  logic [NUM_COUNTERS-1:0]       busy;
  logic [NUM_COUNTERS*NUM_W-1:0] service_number;
  logic                          call_valid;
  logic [3:0]                    call_counter;
  logic                          ticket_reject;

  modport master (
    output button, done,
    input  ticket_number, max_call_number, waiting_count, busy,
           service_number, call_valid, call_counter, ticket_reject
  );

  modport slave (
    input  button, done,
    output ticket_number, max_call_number, waiting_count, busy,
           service_number, call_valid, call_counter, ticket_reject
  );
endinterface

// File: rtl/queue_dispatch_ctrl.sv
// Ticket issue and round-robin dispatch to NUM_COUNTERS service counters.
// Tickets leave in issue order, so the queue is implicit: next call = max_call_number+1.
module qdc_lane #(
  parameter int NUM_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grant_i,
  input  logic             done_i,
  input  logic [NUM_W-1:0] num_i,
  output logic             busy_o,
  output logic [NUM_W-1:0] svc_o
);
  logic             busy_q;
  logic [NUM_W-1:0] svc_q;

  // grant only ever lands on an idle lane, done only on a busy one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      svc_q  <= '0;
    end else if (grant_i) begin
      busy_q <= 1'b1;
      svc_q  <= num_i;
    end else if (done_i && busy_q) begin
      busy_q <= 1'b0;
      svc_q  <= '0;
    end
  end

  assign busy_o = busy_q;
  assign svc_o  = svc_q;
endmodule

module queue_dispatch_ctrl #(
  parameter int NUM_COUNTERS = 5,
  parameter int NUM_W        = 6,
  parameter int MAX_WAIT     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  queue_dispatch_ctrl_if.slave bus
);
  logic [2:0]                              sync_q;
  logic [NUM_W-1:0]                        wc_q, wc_d;
  logic [NUM_W-1:0]                        tkt_q, tkt_d;
  logic [NUM_W-1:0]                        mcn_q, mcn_d;
  logic [3:0]                              rr_q, rr_d;
  logic                                    call_valid_q;
  logic [3:0]                              call_counter_q;
  logic                                    reject_q;
  logic                                    press, issue, dispatch, gnt_vld;
  logic [3:0]                              gnt_idx;
  logic [NUM_W-1:0]                        call_num;
  logic [NUM_COUNTERS-1:0]                 busy;
  logic [NUM_COUNTERS-1:0][NUM_W-1:0]      svc;

  function automatic logic [NUM_W-1:0] next_num(input logic [NUM_W-1:0] x);
    return (x == {NUM_W{1'b1}}) ? NUM_W'(1) : x + NUM_W'(1);
  endfunction

  // sync_q: [0]=s1, [1]=s2, [2]=edge-detect delay
  assign press    = sync_q[1] & ~sync_q[2];
  assign issue    = press && (wc_q < NUM_W'(MAX_WAIT));
  assign call_num = next_num(mcn_q);
  assign dispatch = gnt_vld && (wc_q != '0);

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_COUNTERS) idx = idx - NUM_COUNTERS;
      if (!gnt_vld && !busy[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = 4'(idx);
      end
    end
  end

  always_comb begin
    wc_d  = wc_q;
    tkt_d = issue ? next_num(tkt_q) : tkt_q;
    mcn_d = dispatch ? call_num : mcn_q;
    rr_d  = rr_q;
    if (issue && !dispatch)      wc_d = wc_q + NUM_W'(1);
    else if (!issue && dispatch) wc_d = wc_q - NUM_W'(1);
    if (dispatch) rr_d = (int'(gnt_idx) == NUM_COUNTERS-1) ? 4'd0 : gnt_idx + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q         <= '0;
      wc_q           <= '0;
      tkt_q          <= '0;
      mcn_q          <= '0;
      rr_q           <= '0;
      call_valid_q   <= 1'b0;
      call_counter_q <= '0;
      reject_q       <= 1'b0;
    end else begin
      sync_q         <= {sync_q[1:0], bus.button};
      wc_q           <= wc_d;
      tkt_q          <= tkt_d;
      mcn_q          <= mcn_d;
      rr_q           <= rr_d;
      call_valid_q   <= dispatch;
      call_counter_q <= dispatch ? gnt_idx : 4'd0;
      reject_q       <= press && !issue;
    end
  end

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_lane
    qdc_lane #(.NUM_W(NUM_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .grant_i (dispatch && (gnt_idx == 4'(i))),
      .done_i  (bus.done[i]),
      .num_i   (call_num),
      .busy_o  (busy[i]),
      .svc_o   (svc[i])
    );
  end

  assign bus.ticket_number   = tkt_q;
  assign bus.max_call_number = mcn_q;
  assign bus.waiting_count   = wc_q;
  assign bus.busy            = busy;
  assign bus.service_number  = svc;
  assign bus.call_valid      = call_valid_q;
  assign bus.call_counter    = call_counter_q;
  assign bus.ticket_reject   = reject_q;
endmodule

// File: tb/tb_queue_dispatch_ctrl.sv
// Directed bench: a 5-counter instance and a 1-counter 3-bit instance sharing clk/rst.
module tb_queue_dispatch_ctrl;
  localparam int N = 5, W = 6, MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  queue_dispatch_ctrl_if #(.NUM_COUNTERS(N), .NUM_W(W)) bus ();
  queue_dispatch_ctrl_if #(.NUM_COUNTERS(1), .NUM_W(3)) bus2 ();

  queue_dispatch_ctrl #(.NUM_COUNTERS(N), .NUM_W(W), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  queue_dispatch_ctrl #(.NUM_COUNTERS(1), .NUM_W(3), .MAX_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  int vec_cnt = 0, err_cnt = 0, cyc = 0, rej_cnt = 0;
  bit t4_on = 0, zero_hit = 0;
  typedef struct { int cyc; int ctr; int num; } call_t;
  call_t calls[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] slice(input int i);
    logic [N*W-1:0] f;
    f = bus.service_number;
    return f[i*W +: W];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.call_valid)
      calls.push_back('{cyc, int'(bus.call_counter), int'(slice(int'(bus.call_counter)))});
    if (bus.ticket_reject) rej_cnt++;
  end

  always @(negedge clk) if (t4_on && bus2.ticket_number == 3'd0) zero_hit = 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(output int e0);
    @(negedge clk);
    e0 = cyc + 1;
    bus.button = 1'b1;
    @(negedge clk);
    bus.button = 1'b0;
  endtask

  task automatic pulse_done(input logic [N-1:0] m);
    @(negedge clk);
    bus.done = m;
    @(negedge clk);
    bus.done = '0;
  endtask

  int p[6];
  int dummy;
  bit seen;
  logic [2:0] exp3;

  initial begin
    bus.button = 1'b0; bus.done = '0;
    bus2.button = 1'b0; bus2.done = '0;
    #5;
    chk("rst_ticket", bus.ticket_number, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_call_valid", bus.call_valid, 0);
    tick(2);
    rst = 1'b1;

    // 1: five presses two cycles apart, all counters idle
    for (int i = 0; i < 5; i++) press(p[i]);
    tick(6);
    chk("t1_ncalls", calls.size(), 5);
    for (int i = 0; i < 5 && i < calls.size(); i++) begin
      chk("t1_ctr", calls[i].ctr, i);
      chk("t1_num", calls[i].num, i + 1);
      chk("t1_latency", calls[i].cyc - p[i], 3);
    end
    chk("t1_ticket", bus.ticket_number, 5);
    chk("t1_maxcall", bus.max_call_number, 5);
    chk("t1_wc", bus.waiting_count, 0);
    chk("t1_busy", bus.busy, 5'b11111);

    // 2: all busy, six presses against MAX_WAIT=4
    calls.delete();
    rej_cnt = 0;
    for (int i = 0; i < 6; i++) press(p[i]);
    tick(4);
    chk("t2_rejects", rej_cnt, 2);
    chk("t2_wc", bus.waiting_count, 4);
    chk("t2_ticket", bus.ticket_number, 9);
    chk("t2_ncalls", calls.size(), 0);

    // 3: free counter 2, then counters 0 and 4 together
    pulse_done(5'b00100);
    chk("t3_busy_clr", bus.busy, 5'b11011);
    chk("t3_svc2_clr", slice(2), 0);
    chk("t3_nocall", bus.call_valid, 0);
    tick(1);
    chk("t3_cv", bus.call_valid, 1);
    chk("t3_cc", bus.call_counter, 2);
    chk("t3_svc2", slice(2), 6);
    chk("t3_wc", bus.waiting_count, 3);
    pulse_done(5'b10001);
    chk("t3b_busy", bus.busy, 5'b01110);
    chk("t3b_nocall", bus.call_valid, 0);
    tick(1);
    chk("t3b_cv1", bus.call_valid, 1);
    chk("t3b_cc1", bus.call_counter, 4);
    chk("t3b_svc4", slice(4), 7);
    tick(1);
    chk("t3b_cv2", bus.call_valid, 1);
    chk("t3b_cc2", bus.call_counter, 0);
    chk("t3b_svc0", slice(0), 8);
    chk("t3b_wc", bus.waiting_count, 1);

    // 5: done on the only candidate with one ticket waiting, then done on an idle counter
    pulse_done(5'b00010);
    chk("t5_nocall", bus.call_valid, 0);
    chk("t5_busy", bus.busy, 5'b11101);
    tick(1);
    chk("t5_cv", bus.call_valid, 1);
    chk("t5_cc", bus.call_counter, 1);
    chk("t5_svc1", slice(1), 9);
    chk("t5_wc", bus.waiting_count, 0);
    pulse_done(5'b01000);
    chk("t5_busy3", bus.busy, 5'b10111);
    chk("t5_svc3", slice(3), 0);
    pulse_done(5'b01000);
    chk("t5_idle_done_busy", bus.busy, 5'b10111);
    chk("t5_idle_done_cv", bus.call_valid, 0);
    chk("t5_idle_done_wc", bus.waiting_count, 0);

    // 4: 3-bit numbers on a single counter wrap 7 -> 1
    for (int i = 0; i < 8; i++) begin
      exp3 = (i < 7) ? 3'(i + 1) : 3'd1;
      @(negedge clk) bus2.button = 1'b1;
      @(negedge clk) bus2.button = 1'b0;
      seen = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
        @(negedge clk);
        if (bus2.call_valid) seen = 1;
      end
      chk("t4_call_seen", seen, 1);
      chk("t4_svc", bus2.service_number, exp3);
      chk("t4_ticket", bus2.ticket_number, exp3);
      t4_on = 1;
      @(negedge clk) bus2.done = 1'b1;
      @(negedge clk) bus2.done = 1'b0;
      chk("t4_busy_clr", bus2.busy, 0);
    end
    t4_on = 0;
    chk("t4_no_zero_ticket", zero_hit, 0);

    // 6: asynchronous reset with tickets waiting and counters busy
    for (int i = 0; i < 4; i++) press(dummy);
    tick(4);
    chk("t6_pre_wc", bus.waiting_count, 3);
    chk("t6_pre_busy", bus.busy, 5'b11111);
    chk("t6_pre_ticket", bus.ticket_number, 13);
    #3 rst = 1'b0;
    #1;
    chk("t6_ticket", bus.ticket_number, 0);
    chk("t6_maxcall", bus.max_call_number, 0);
    chk("t6_wc", bus.waiting_count, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_svc", bus.service_number, 0);
    @(negedge clk) rst = 1'b1;
    calls.delete();
    press(p[0]);
    tick(4);
    chk("t6_ncalls", calls.size(), 1);
    if (calls.size() > 0) begin
      chk("t6_ctr", calls[0].ctr, 0);
      chk("t6_num", calls[0].num, 1);
    end
    chk("t6_ticket_after", bus.ticket_number, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
